pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Decode-stage control-transfer resolver that drives the branch/jump select inputs of the fetch-stage PC multiplexer. It evaluates BEQ/BNE/J/JAL/JR/JALR in ID and produces a registered one-cycle redirect (target address plus select). It also produces a flush for the wrong-path instructions. It holds a redirect across hazard-unit stalls so that no redirect is lost.

## Interface
- NB, 32, datapath/address width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  ID holds a valid instruction
- i_stall  in  1  hazard unit freezes PC and IF/ID this cycle
- i_opcode  in  6  instr[31:26]
- i_funct  in  6  instr[5:0]
- i_imm  in  16  instr[15:0]
- i_target  in  26  instr[25:0]
- i_rs_data  in  NB  forwarded rs value
- i_rt_data  in  NB  forwarded rt value
- i_pc4  in  NB  PC+4 of the ID instruction
- o_branch  out  1  taken-branch select to PC mux
- o_branch_addr  out  NB  branch target
- o_jump  out  1  jump select to PC mux
- o_jump_addr  out  NB  jump target
- o_flush  out  1  clear IF/ID and bubble ID/EX
- o_taken_cnt  out  32  taken branches (only with macro)
- o_redirect_cnt  out  32  all redirects (only with macro)

## Operation
- Decode rules:
  - BEQ (000100): taken if rs==rt.
  - BNE (000101): taken if rs!=rt.
  - J/JAL (000010/000011): always redirect.
  - R-type (000000) with funct JR (001000) or JALR (001001): always redirect.
  - All other instructions: no redirect.
- Target arithmetic, modulo 2^NB:
  - Branch target = i_pc4 + (sign-extended i_imm << 2).
  - J/JAL target = {i_pc4[NB-1:28], i_target, 2'b00}.
  - JR/JALR target = i_rs_data; the low 2 bits pass through unmodified.
- The linking instructions (JAL/JALR) are resolved here for the redirect only; link writeback is handled elsewhere.
- FSM states are IDLE and REDIRECT.
- IDLE:
  - A redirect is resolved when i_valid & !i_stall and the instruction requires one.
  - On resolve, load the target and select into registers and go to REDIRECT.
  - Otherwise stay in IDLE with all outputs low.
- REDIRECT:
  - Assert exactly one of o_branch/o_jump with its address, and assert o_flush.
  - Ignore the ID instruction, because it is wrong-path.
  - If i_stall, stay in REDIRECT with all outputs held.
  - Else return to IDLE.
- o_branch and o_jump are never high together. o_branch_addr and o_jump_addr are zero when their select is low.

## Timing
- Reset (async assert, sync release): state IDLE; o_branch, o_jump, o_flush = 0; both addresses = 0; counters = 0.
- Latency: an instruction resolved at edge-sampled cycle N produces outputs in cycle N+1. The PC loads the target at the end of N+1.
- A redirect lasts 1 cycle, plus 1 cycle per cycle that i_stall is high while in REDIRECT.
- A resolving instruction in ID during i_stall is not captured; it is re-evaluated when the stall drops.
- Back-to-back control transfers: the second instruction is in ID during REDIRECT, so it is wrong-path and is dropped. The earliest next redirect is at N+3.
- Reset asserted mid-REDIRECT: outputs clear immediately (asynchronously). The pending redirect is discarded.

## Configuration
- PC_REDIRECT_STATS_EN defined:
  - o_taken_cnt increments on each entry into REDIRECT caused by a taken branch.
  - o_redirect_cnt increments on every entry into REDIRECT.
  - Stall-hold cycles do not count.
  - Both counters are 32 bits and wrap modulo 2^32.
- PC_REDIRECT_STATS_EN undefined: both counter ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL.
  - Funct constants FN_JR, FN_JALR.
  - State encoding ST_IDLE/ST_REDIRECT.
- Sub-module `branch_target_calc`: combinational. Computes the branch target, the jump target and the taken/redirect-kind flags. The top level holds the FSM, the output registers and the optional counters.

## Test plan
- BEQ with rs=rt=5, i_pc4=0x100, imm=0x0004, no stall -> next cycle o_branch=1, o_branch_addr=0x110, o_flush=1 for exactly one cycle; o_jump=0.
- BNE with rs=rt=7 -> no redirect; all outputs stay 0. BEQ with imm=0xFFFF, pc4=0x100 -> o_branch_addr=0xFC.
- J with target=0x0000040, pc4=0x10000004 -> o_jump=1, o_jump_addr=0x10000100. JR with rs=0x2000 -> o_jump_addr=0x2000.
- Redirect in REDIRECT with i_stall high for 3 cycles -> o_jump/o_flush held for 4 cycles with a stable address, then IDLE.
- JAL followed immediately by BEQ (taken) -> single redirect to the JAL target; BEQ ignored.
- Deassert i_rst_n during REDIRECT -> all outputs 0 in the same cycle. With PC_REDIRECT_STATS_EN: 2 taken branches and 1 jump -> o_taken_cnt=2, o_redirect_cnt=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and redirect-FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  // True for any opcode/funct pair that unconditionally changes the PC.
  function automatic logic is_jump(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_J) || (opcode == OP_JAL) ||
           ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// ID-stage instruction fields in, PC-mux redirect controls out.
// Counter signals exist only when PC_REDIRECT_STATS_EN is defined.
interface pc_redirect_unit_if #(
  parameter int unsigned NB = 32
);
  logic          i_valid;
  logic          i_stall;
  logic [5:0]    i_opcode;
  logic [5:0]    i_funct;
  logic [15:0]   i_imm;
  logic [25:0]   i_target;
  logic [NB-1:0] i_rs_data;
  logic [NB-1:0] i_rt_data;
  logic [NB-1:0] i_pc4;
  logic          o_branch;
  logic [NB-1:0] o_branch_addr;
  logic          o_jump;
  logic [NB-1:0] o_jump_addr;
  logic          o_flush;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0]   o_taken_cnt;
  logic [31:0]   o_redirect_cnt;
`endif

`ifdef PC_REDIRECT_STATS_EN
  modport master (
    output i_valid, i_stall, i_opcode, i_funct, i_imm, i_target, i_rs_data, i_rt_data, i_pc4,
    input  o_branch, o_branch_addr, o_jump, o_jump_addr, o_flush, o_taken_cnt, o_redirect_cnt
  );
  modport slave (
    input  i_valid, i_stall, i_opcode, i_funct, i_imm, i_target, i_rs_data, i_rt_data, i_pc4,
    output o_branch, o_branch_addr, o_jump, o_jump_addr, o_flush, o_taken_cnt, o_redirect_cnt
  );
`else
  modport master (
    output i_valid, i_stall, i_opcode, i_funct, i_imm, i_target, i_rs_data, i_rt_data, i_pc4,
    input  o_branch, o_branch_addr, o_jump, o_jump_addr, o_flush
  );
  modport slave (
    input  i_valid, i_stall, i_opcode, i_funct, i_imm, i_target, i_rs_data, i_rt_data, i_pc4,
    output o_branch, o_branch_addr, o_jump, o_jump_addr, o_flush
  );
`endif

endinterface

// File: rtl/pc_redirect_unit_branch_target_calc.sv
// Combinational decode of control transfers: taken flag, jump flag and both targets.
module branch_target_calc
  import mips_pkg::*;
#(
  parameter int unsigned NB = 32
) (
  input  logic [5:0]    opcode_i,
  input  logic [5:0]    funct_i,
  input  logic [15:0]   imm_i,
  input  logic [25:0]   target_i,
  input  logic [NB-1:0] rs_data_i,
  input  logic [NB-1:0] rt_data_i,
  input  logic [NB-1:0] pc4_i,
  output logic          br_taken_o,
  output logic          jump_o,
  output logic [NB-1:0] branch_addr_o,
  output logic [NB-1:0] jump_addr_o
);

  logic          rs_eq_rt;
  logic [NB-1:0] br_offset;

  // Decode taken/jump and compute both candidate targets.
  always_comb begin
    rs_eq_rt      = (rs_data_i == rt_data_i);
    br_taken_o    = ((opcode_i == OP_BEQ) && rs_eq_rt) || ((opcode_i == OP_BNE) && !rs_eq_rt);
    jump_o        = is_jump(opcode_i, funct_i);
    br_offset     = {{(NB-18){imm_i[15]}}, imm_i, 2'b00};
    branch_addr_o = pc4_i + br_offset;
    // Register jumps pass rs through untouched, including misaligned low bits.
    if (opcode_i == OP_RTYPE) begin
      jump_addr_o = rs_data_i;
    end else begin
      jump_addr_o = {pc4_i[NB-1:28], target_i, 2'b00};
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Decode-stage PC redirect resolver: registered one-cycle branch/jump select plus flush,
// held across stalls. Optional statistics counters with PC_REDIRECT_STATS_EN.
module pc_redirect_unit
  import mips_pkg::*;
#(
  parameter int unsigned NB = 32
) (
  input logic              i_clk,
  input logic              i_rst_n,
  pc_redirect_unit_if.slave bus
);

  state_e        state_q;
  logic          branch_q;
  logic          jump_q;
  logic          flush_q;
  logic [NB-1:0] branch_addr_q;
  logic [NB-1:0] jump_addr_q;

  logic          br_taken;
  logic          jump_req;
  logic [NB-1:0] br_addr;
  logic [NB-1:0] jmp_addr;
  logic          resolve;

  branch_target_calc #(
    .NB (NB)
  ) u_calc (
    .opcode_i      (bus.i_opcode),
    .funct_i       (bus.i_funct),
    .imm_i         (bus.i_imm),
    .target_i      (bus.i_target),
    .rs_data_i     (bus.i_rs_data),
    .rt_data_i     (bus.i_rt_data),
    .pc4_i         (bus.i_pc4),
    .br_taken_o    (br_taken),
    .jump_o        (jump_req),
    .branch_addr_o (br_addr),
    .jump_addr_o   (jmp_addr)
  );

  // Only capture from IDLE; anything in ID during REDIRECT is wrong-path.
  assign resolve = (state_q == ST_IDLE) && bus.i_valid && !bus.i_stall && (br_taken || jump_req);

  // Redirect FSM with registered selects, addresses and flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      flush_q       <= 1'b0;
      branch_addr_q <= '0;
      jump_addr_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (resolve) begin
            state_q       <= ST_REDIRECT;
            branch_q      <= br_taken;
            jump_q        <= jump_req;
            flush_q       <= 1'b1;
            branch_addr_q <= br_taken ? br_addr : '0;
            jump_addr_q   <= jump_req ? jmp_addr : '0;
          end
        end
        ST_REDIRECT: begin
          // Hold everything while the PC is frozen so the redirect is not lost.
          if (!bus.i_stall) begin
            state_q       <= ST_IDLE;
            branch_q      <= 1'b0;
            jump_q        <= 1'b0;
            flush_q       <= 1'b0;
            branch_addr_q <= '0;
            jump_addr_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_branch      = branch_q;
  assign bus.o_jump        = jump_q;
  assign bus.o_flush       = flush_q;
  assign bus.o_branch_addr = branch_addr_q;
  assign bus.o_jump_addr   = jump_addr_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Count entries into REDIRECT only; stall-hold cycles never re-enter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      taken_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else if (resolve) begin
      redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (br_taken) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign bus.o_taken_cnt    = taken_cnt_q;
  assign bus.o_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit (counters checked with PC_REDIRECT_STATS_EN).
module tb_pc_redirect_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_redirect_unit_if #(.NB(32)) bus ();

  pc_redirect_unit #(
    .NB (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic br, input logic [31:0] ba,
                            input logic jp, input logic [31:0] ja, input logic fl);
    check_eq({tag, ".branch"}, {31'd0, bus.o_branch}, {31'd0, br});
    check_eq({tag, ".branch_addr"}, bus.o_branch_addr, ba);
    check_eq({tag, ".jump"}, {31'd0, bus.o_jump}, {31'd0, jp});
    check_eq({tag, ".jump_addr"}, bus.o_jump_addr, ja);
    check_eq({tag, ".flush"}, {31'd0, bus.o_flush}, {31'd0, fl});
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc4);
    bus.i_valid   = 1'b1;
    bus.i_opcode  = op;
    bus.i_funct   = fn;
    bus.i_imm     = imm;
    bus.i_target  = tgt;
    bus.i_rs_data = rs;
    bus.i_rt_data = rt;
    bus.i_pc4     = pc4;
  endtask

  task automatic idle_in();
    bus.i_valid   = 1'b0;
    bus.i_opcode  = 6'd0;
    bus.i_funct   = 6'd0;
    bus.i_imm     = 16'd0;
    bus.i_target  = 26'd0;
    bus.i_rs_data = 32'd0;
    bus.i_rt_data = 32'd0;
    bus.i_pc4     = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_stall = 1'b0;
    idle_in();
    #12;
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef PC_REDIRECT_STATS_EN
    check_eq("reset.taken_cnt", bus.o_taken_cnt, 32'd0);
    check_eq("reset.redirect_cnt", bus.o_redirect_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // BEQ taken: 0x100 + (4<<2) = 0x110, one cycle only.
    drive(OP_BEQ, 6'd0, 16'h0004, 26'd0, 32'd5, 32'd5, 32'h100);
    step();
    expect_out("beq_taken", 1'b1, 32'h110, 1'b0, 32'h0, 1'b1);
    idle_in();
    step();
    expect_out("beq_taken_end", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // BNE with equal operands: not taken.
    drive(OP_BNE, 6'd0, 16'h0004, 26'd0, 32'd7, 32'd7, 32'h100);
    step();
    expect_out("bne_not_taken", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle_in();
    step();

    // Negative offset: 0x100 - 4 = 0xFC.
    drive(OP_BEQ, 6'd0, 16'hFFFF, 26'd0, 32'd9, 32'd9, 32'h100);
    step();
    expect_out("beq_neg", 1'b1, 32'hFC, 1'b0, 32'h0, 1'b1);
    idle_in();
    step();

    // J: {0x1, 0x40, 00} = 0x10000100.
    drive(OP_J, 6'd0, 16'd0, 26'h0000040, 32'd0, 32'd0, 32'h10000004);
    step();
    expect_out("j", 1'b0, 32'h0, 1'b1, 32'h10000100, 1'b1);
    idle_in();
    step();

    drive(OP_RTYPE, FN_JR, 16'd0, 26'd0, 32'h2000, 32'd0, 32'h400);
    step();
    expect_out("jr", 1'b0, 32'h0, 1'b1, 32'h2000, 1'b1);
    idle_in();
    step();

    // JALR: low bits of rs pass through.
    drive(OP_RTYPE, FN_JALR, 16'd0, 26'd0, 32'h2003, 32'd0, 32'h400);
    step();
    expect_out("jalr", 1'b0, 32'h0, 1'b1, 32'h2003, 1'b1);
    idle_in();
    step();

    // Non-control R-type (ADD funct 0x20): no redirect.
    drive(OP_RTYPE, 6'h20, 16'd0, 26'd0, 32'h2000, 32'd0, 32'h400);
    step();
    expect_out("add", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle_in();

    // Stall in IDLE blocks capture; instruction resolves once stall drops.
    drive(OP_BEQ, 6'd0, 16'h0004, 26'd0, 32'd1, 32'd1, 32'h200);
    bus.i_stall = 1'b1;
    step();
    expect_out("idle_stall", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    bus.i_stall = 1'b0;
    step();
    expect_out("after_stall", 1'b1, 32'h210, 1'b0, 32'h0, 1'b1);
    idle_in();
    step();

    // Stall during REDIRECT for 3 cycles: held for 4 cycles total.
    drive(OP_J, 6'd0, 16'd0, 26'h0000100, 32'd0, 32'd0, 32'h20000000);
    step();
    expect_out("hold0", 1'b0, 32'h0, 1'b1, 32'h20000400, 1'b1);
    idle_in();
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("hold%0d", i + 1), 1'b0, 32'h0, 1'b1, 32'h20000400, 1'b1);
    end
    bus.i_stall = 1'b0;
    step();
    expect_out("hold_end", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // JAL then taken BEQ back-to-back: BEQ is wrong-path and dropped.
    drive(OP_JAL, 6'd0, 16'd0, 26'h0000010, 32'd0, 32'd0, 32'h00000008);
    step();
    expect_out("jal", 1'b0, 32'h0, 1'b1, 32'h00000040, 1'b1);
    drive(OP_BEQ, 6'd0, 16'h0008, 26'd0, 32'd3, 32'd3, 32'h00000048);
    step();
    expect_out("b2b_drop", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle_in();
    step();
    expect_out("b2b_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Async reset mid-REDIRECT clears outputs without a clock edge.
    drive(OP_J, 6'd0, 16'd0, 26'h0000001, 32'd0, 32'd0, 32'h0);
    step();
    expect_out("pre_rst", 1'b0, 32'h0, 1'b1, 32'h4, 1'b1);
    idle_in();
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    expect_out("post_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

`ifdef PC_REDIRECT_STATS_EN
    check_eq("cnt_after_rst.taken", bus.o_taken_cnt, 32'd0);
    check_eq("cnt_after_rst.redirect", bus.o_redirect_cnt, 32'd0);
    drive(OP_BEQ, 6'd0, 16'h0001, 26'd0, 32'd2, 32'd2, 32'h100);
    step();
    idle_in();
    step();
    drive(OP_BNE, 6'd0, 16'h0001, 26'd0, 32'd2, 32'd3, 32'h100);
    step();
    idle_in();
    // A stall-hold cycle must not count again.
    bus.i_stall = 1'b1;
    step();
    bus.i_stall = 1'b0;
    step();
    drive(OP_J, 6'd0, 16'd0, 26'h0000002, 32'd0, 32'd0, 32'h0);
    step();
    idle_in();
    step();
    check_eq("stats.taken_cnt", bus.o_taken_cnt, 32'd2);
    check_eq("stats.redirect_cnt", bus.o_redirect_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
